// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } hilo_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } hilo_state_t;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] DIVZ_LO   = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_div_iter.sv
// Unsigned restoring divider: start loads operands, then one quotient bit per cycle
// for DIV_ITERS cycles; abort stops iteration. No backpressure, results hold once finished.
module hilo_div_iter
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [5:0]  cnt;
  logic [31:0] dvsr;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  // Partial remainder is kept below dvsr, so the shifted value fits in 33 bits.
  assign rem_sh = {remainder, quotient[31]};
  assign diff   = rem_sh - {1'b0, dvsr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 6'd0;
      dvsr      <= 32'd0;
      quotient  <= 32'd0;
      remainder <= 32'd0;
    end else if (start) begin
      cnt       <= 6'(DIV_ITERS);
      dvsr      <= divisor;
      quotient  <= dividend;
      remainder <= 32'd0;
    end else if (abort) begin
      cnt <= 6'd0;
    end else if (cnt != 6'd0) begin
      cnt <= cnt - 6'd1;
      if (!diff[32]) begin
        remainder <= diff[31:0];
        quotient  <= {quotient[30:0], 1'b1};
      end else begin
        remainder <= rem_sh[31:0];
        quotient  <= {quotient[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: MTHI/MTLO in one cycle, mult stalls MUL_CYCLES+1, div stalls 33; HI/LO commit at end of DONE.
// HILO_BYPASS_EN makes hi_o/lo_o show the value being written this cycle.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              stall_req,
  output logic              busy,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  hilo_state_t         state;
  hilo_op_t            op_e;
  logic [5:0]          cnt;
  logic [DATA_W-1:0]   hi, lo, a_q, b_q;
  logic                sgn_q, div_q;
  logic                is_mul, is_div, is_sgn, accept;
  logic [2*DATA_W-1:0] ma, mb, mul_full, prod;
  logic [DATA_W-1:0]   a_mag, b_mag, quo, rem, q_fix, r_fix;
  logic [DATA_W-1:0]   res_hi, res_lo, hi_wd, lo_wd;
  logic                hi_we, lo_we;

  assign op_e   = hilo_op_t'(op);
  assign is_mul = (op_e == OP_MULT) || (op_e == OP_MULTU);
  assign is_div = (op_e == OP_DIV) || (op_e == OP_DIVU);
  assign is_sgn = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign accept = (state == ST_IDLE) && op_valid && !flush && (is_mul || is_div);

  assign stall_req = accept || (state == ST_MUL) || (state == ST_DIV);
  assign busy      = (state != ST_IDLE);

  // Sign-extending to full width makes the low 2*DATA_W bits of an unsigned multiply signed-correct.
  assign ma       = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
  assign mb       = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
  assign mul_full = ma * mb;

  assign a_mag = (is_sgn && src_a[DATA_W-1]) ? -src_a : src_a;
  assign b_mag = (is_sgn && src_b[DATA_W-1]) ? -src_b : src_b;

  hilo_div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_div),
    .abort     (flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  assign q_fix = (sgn_q && (a_q[DATA_W-1] ^ b_q[DATA_W-1])) ? -quo : quo;
  assign r_fix = (sgn_q && a_q[DATA_W-1]) ? -rem : rem;

  always_comb begin
    res_hi = prod[2*DATA_W-1:DATA_W];
    res_lo = prod[DATA_W-1:0];
    if (div_q) begin
      if (b_q == '0) begin
        res_hi = a_q;
        res_lo = DIVZ_LO;
      end else begin
        res_hi = r_fix;
        res_lo = q_fix;
      end
    end
  end

  always_comb begin
    hi_we = 1'b0;
    lo_we = 1'b0;
    hi_wd = src_a;
    lo_wd = src_a;
    if (!flush) begin
      if (state == ST_IDLE && op_valid) begin
        hi_we = (op_e == OP_MTHI);
        lo_we = (op_e == OP_MTLO);
      end else if (state == ST_DONE) begin
        hi_we = 1'b1;
        lo_we = 1'b1;
        hi_wd = res_hi;
        lo_wd = res_lo;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 6'd0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      div_q <= 1'b0;
      prod  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (hi_we) hi <= hi_wd;
      if (lo_we) lo <= lo_wd;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= is_div ? ST_DIV : ST_MUL;
            cnt   <= 6'd1;
            a_q   <= src_a;
            b_q   <= src_b;
            sgn_q <= is_sgn;
            div_q <= is_div;
          end
        end
        ST_MUL: begin
          prod <= mul_full;
          if (flush) begin
            state <= ST_IDLE;
            cnt   <= 6'd0;
          end else if (cnt == 6'(MUL_CYCLES)) begin
            state <= ST_DONE;
            cnt   <= 6'd0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        ST_DIV: begin
          if (flush) begin
            state <= ST_IDLE;
            cnt   <= 6'd0;
          end else if (cnt == 6'(DIV_ITERS)) begin
            state <= ST_DONE;
            cnt   <= 6'd0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        // The held instruction leaves EX here; its op_valid must not start a new operation.
        ST_DONE: begin
          state <= ST_IDLE;
          cnt   <= 6'd0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef HILO_BYPASS_EN
  assign hi_o = hi_we ? hi_wd : hi;
  assign lo_o = lo_we ? lo_wd : lo;
`else
  assign hi_o = hi;
  assign lo_o = lo;
`endif

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with hand-computed HI/LO results and stall lengths.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

`ifdef HILO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        stall_req, busy;
  logic [31:0] hi_o, lo_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(.DATA_W(32), .MUL_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Holds the op while stall_req is high, returns stall length and HI/LO seen in the final (unstalled) cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n, output logic [31:0] hi_at, output logic [31:0] lo_at);
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_req) break;
      n++;
      @(posedge clk); #1;
    end
    hi_at = hi_o;
    lo_at = lo_o;
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NONE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] h, l;

    #2;
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Preload HI/LO so the mid-operation reset has something to clear.
    run_op(OP_MTHI, 32'h11, 32'd0, n, h, l);
    chk("mthi_stall", n, 0);
    run_op(OP_MTLO, 32'h22, 32'd0, n, h, l);
    chk("pre_hi", hi_o, 32'h11);
    chk("pre_lo", lo_o, 32'h22);

    // Reset in cycle 10 of a divide.
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    chk("middiv_busy", {31'd0, busy}, 32'd1);
    op_valid = 1'b0; op = OP_NONE;
    rst = 1'b1;
    #1;
    chk("arst_busy",  {31'd0, busy}, 32'd0);
    chk("arst_stall", {31'd0, stall_req}, 32'd0);
    chk("arst_hi", hi_o, 32'd0);
    chk("arst_lo", lo_o, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // -3 * 7 = -21
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, n, h, l);
    chk("mult_stall", n, 3);
    chk("mult_done_hi", h, BYP ? 32'hFFFF_FFFF : 32'd0);
    chk("mult_done_lo", l, BYP ? 32'hFFFF_FFEB : 32'd0);
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFEB);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, h, l);
    chk("multu_stall", n, 3);
    chk("multu_hi", hi_o, 32'hFFFF_FFFE);
    chk("multu_lo", lo_o, 32'h0000_0001);

    // op_valid is still high in DONE; the controller must return to IDLE.
    run_op(OP_DIVU, 32'd100, 32'd7, n, h, l);
    chk("divu_stall", n, 33);
    chk("divu_done_hi", h, BYP ? 32'd2 : 32'hFFFF_FFFE);
    chk("divu_norestart", {31'd0, busy}, 32'd0);
    chk("divu_hi", hi_o, 32'd2);
    chk("divu_lo", lo_o, 32'd14);
    @(negedge clk);
    chk("divu_idle_stall", {31'd0, stall_req}, 32'd0);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n, h, l);
    chk("div_neg_stall", n, 33);
    chk("div_neg_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi_o, 32'hFFFF_FFFF);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n, h, l);
    chk("div_ovf_lo", lo_o, 32'h8000_0000);
    chk("div_ovf_hi", hi_o, 32'd0);

    run_op(OP_DIVU, 32'h1234_5678, 32'd0, n, h, l);
    chk("divz_stall", n, 33);
    chk("divz_lo", lo_o, 32'hFFFF_FFFF);
    chk("divz_hi", hi_o, 32'h1234_5678);

    run_op(OP_DIV, 32'h8000_0005, 32'd0, n, h, l);
    chk("sdivz_lo", lo_o, 32'hFFFF_FFFF);
    chk("sdivz_hi", hi_o, 32'h8000_0005);

    run_op(OP_MTHI, 32'hA5A5_A5A5, 32'd0, n, h, l);
    chk("mthi_a5_stall", n, 0);
    chk("mthi_a5_wrcycle", h, BYP ? 32'hA5A5_A5A5 : 32'h8000_0005);
    chk("mthi_a5_hi", hi_o, 32'hA5A5_A5A5);

    // Divide flushed in cycle 12.
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_DIV; src_a = 32'd5; src_b = 32'd1;
    repeat (12) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_cyc_stall", {31'd0, stall_req}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0; op = OP_NONE;
    @(negedge clk);
    chk("flush_next_stall", {31'd0, stall_req}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi_o, 32'hA5A5_A5A5);
    chk("flush_lo", lo_o, 32'hFFFF_FFFF);

    run_op(OP_MTLO, 32'd1, 32'd0, n, h, l);
    chk("mtlo_wrcycle", l, BYP ? 32'd1 : 32'hFFFF_FFFF);
    chk("mtlo_lo", lo_o, 32'd1);

    // Flushed ops in IDLE are neither accepted nor written.
    @(posedge clk); #1;
    op_valid = 1'b1; flush = 1'b1; op = OP_MTHI; src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("idle_flush_byp", hi_o, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    op = OP_MULT; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    chk("idle_flush_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0; op = OP_NONE;
    chk("idle_flush_busy", {31'd0, busy}, 32'd0);
    chk("idle_flush_hi", hi_o, 32'hA5A5_A5A5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Sequencing controller that owns the HI/LO register pair for the MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage.
- Runs a multi-cycle multiply and a 32-iteration radix-2 divider, stalls the pipeline until the result is ready, then commits HI/LO.
- Drives hi_o/lo_o to the EX-stage MFHI/MFLO path.

Parameters:
- DATA_W, 32, operand and HI/LO width (only 32 supported).
- MUL_CYCLES, 2, cycles spent in MUL state (legal 1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- op_valid  in  1  EX-stage instruction targets HI/LO.
- op  in  3  hilo_op_t: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- src_a  in  DATA_W  rs value (dividend / multiplicand / MTxx data).
- src_b  in  DATA_W  rt value (divisor / multiplier).
- flush  in  1  synchronous squash of the EX-stage instruction.
- stall_req  out  1  hold IF..EX this cycle.
- busy  out  1  state != IDLE.
- hi_o  out  DATA_W  current HI.
- lo_o  out  DATA_W  current LO.

Behaviour:
- Reset (async): state=IDLE, HI=0, LO=0, counter=0. Outputs: stall_req=0, busy=0, hi_o=0, lo_o=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - op_valid and op in {MULT, MULTU}, no flush: latch operands, go to MUL; stall_req=1 combinationally this cycle (cycle 0).
  - op in {DIV, DIVU}: same, go to DIV.
  - op MTHI/MTLO, no flush: write src_a to HI/LO at this clock edge; no stall; stay in IDLE.
- MUL: counter counts 1..MUL_CYCLES. stall_req=1. After MUL_CYCLES cycles, go to DONE.
- DIV: 32 iteration cycles on operand magnitudes. stall_req=1. Then go to DONE.
- DONE: stall_req=0, so the instruction leaves EX. HI/LO are written at the end of DONE. Next state is IDLE. op_valid seen in DONE is the same instruction and must not restart.
- Latency: stall_req high for MUL_CYCLES+1 cycles (mult) or 33 cycles (div), counted from the accept cycle.
- Multiply arithmetic: full 64-bit product, HI=[63:32], LO=[31:0]. MULT is signed, MULTU unsigned.
- Divide arithmetic:
  - LO=quotient, HI=remainder.
  - Signed: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - 0x80000000 / -1: LO=0x80000000, HI=0.
- Divide by zero: latency unchanged. LO=0xFFFFFFFF, HI=src_a (both signed and unsigned).
- flush:
  - In MUL/DIV/DONE: go to IDLE next cycle, HI/LO unchanged, stall_req drops the cycle after flush.
  - In IDLE: nothing is accepted or written.
- Ops arriving while not in IDLE (other than the held one) are ignored.

Optional Feature:
HILO_BYPASS_EN
- Defined: hi_o/lo_o are combinational. They show the value being written this cycle, i.e. the MTHI/MTLO data or the DONE result (flush suppresses the bypass), so a dependent MFHI in the next instruction needs no extra hazard logic.
- Undefined: hi_o/lo_o come straight from the registers and the new value is visible one cycle after the write. The external hazard unit must stall one cycle for MFxx after MTxx/DONE.

Decomposition:
- Package hilo_pkg holds:
  - hilo_op_t enum (3-bit);
  - hilo_state_t enum;
  - DIV_ITERS=32;
  - the divide-by-zero LO constant.
- Sub-module hilo_div_iter: unsigned restoring divider with start, 32-cycle iteration and quotient/remainder outputs.
- Sign correction and the multiplier stay in the controller.

Test Plan:
1. Reset asserted mid-DIV (cycle 10) -> state IDLE immediately; hi_o=lo_o=0, stall_req=0, busy=0.
2. MULT a=0xFFFFFFFD, b=7, MUL_CYCLES=2 -> stall_req high 3 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
3. DIVU a=100, b=7 -> stall_req high exactly 33 cycles; HI=2, LO=14; a second op_valid held during DONE does not restart.
4. DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
5. DIVU a=0x12345678, b=0 -> 33-cycle stall; LO=0xFFFFFFFF, HI=0x12345678.
6. MTHI 0xA5A5A5A5 then DIV flushed at cycle 12 -> HI stays 0xA5A5A5A5, stall_req low next cycle, following MTLO 0x1 lands. Check hi_o timing with and without HILO_BYPASS_EN.
